// File: rtl/parking_meter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : parking_meter_ctrl
//  Description : Sequencing controller for the parking-meter time register.
//                Arbitrates add-time buttons, preset switches and the 1 Hz
//                countdown tick onto a 4-digit BCD time register (one
//                operation per clock) and runs the EXPIRED/LOW/RUN state
//                machine that drives display blanking.
//  Ports       :
//    clk        - system clock, rising edge
//    rst_n      - synchronous active-low reset
//    tick_1hz   - one-cycle countdown strobe
//    tick_2hz   - one-cycle flash-phase strobe
//    btn_u/l/r/d- one-cycle add requests (synchronised)
//    sw0, sw1   - preset levels (sw1 has priority)
//    time_bcd   - current time, BCD, digit 3 in [15:12]
//    blank      - display blank request
//    expired    - time is 0000
//    busy       - any add or tick request still pending
//  Revision    : 1.0 - initial release
// ============================================================================
module parking_meter_ctrl #(
  parameter logic [15:0] ADD_U  = 16'h0010,
  parameter logic [15:0] ADD_L  = 16'h0180,
  parameter logic [15:0] ADD_R  = 16'h0200,
  parameter logic [15:0] ADD_D  = 16'h0550,
  parameter logic [15:0] PRE0   = 16'h0010,
  parameter logic [15:0] PRE1   = 16'h0205,
  parameter logic [15:0] LOW_TH = 16'h0200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_1hz,
  input  logic        tick_2hz,
  input  logic        btn_u,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        btn_d,
  input  logic        sw0,
  input  logic        sw1,
  output logic [15:0] time_bcd,
  output logic        blank,
  output logic        expired,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_EXPIRED = 2'd0,
    ST_LOW     = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  // Request vector bit positions; lower index = higher service priority.
  localparam int c_REQ_U    = 0;
  localparam int c_REQ_L    = 1;
  localparam int c_REQ_R    = 2;
  localparam int c_REQ_D    = 3;
  localparam int c_REQ_TICK = 4;

  localparam logic [15:0] c_MAX_TIME = 16'h9999;

  state_t      state, state_nx;
  logic [15:0] time_q, time_nx;
  logic [4:0]  pend_q, pend_nx;
  logic [1:0]  phase_q, phase_nx;
  logic        blank_q, blank_nx;

  logic [4:0]  req;
  logic [4:0]  grant;
  logic [15:0] add_val;
  logic [16:0] sum;

  // Digit-wise BCD add; bit 16 is the carry out of the thousands digit.
  function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] r;
    logic [4:0]  s;
    logic        c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, c};
      if (s > 5'd9) begin
        s = s + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*i +: 4] = s[3:0];
    end
    r[16] = c;
    return r;
  endfunction

  // BCD decrement by one with borrow ripple; caller guarantees a != 0.
  function automatic logic [15:0] bcd_dec(input logic [15:0] a);
    logic [15:0] r;
    logic        b;
    r = a;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (a[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = a[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_EXPIRED;
      time_q  <= '0;
      pend_q  <= '0;
      phase_q <= '0;
      blank_q <= 1'b0;
    end else begin
      state   <= state_nx;
      time_q  <= time_nx;
      pend_q  <= pend_nx;
      phase_q <= phase_nx;
      blank_q <= blank_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Arbitration, datapath, next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    time_nx  = time_q;
    pend_nx  = pend_q;
    state_nx = state;
    phase_nx = phase_q;
    blank_nx = 1'b0;
    add_val  = '0;

    // A strobe this cycle competes alongside already-pending requests, so an
    // idle source is served in the same cycle it arrives.
    req     = pend_q;
    req[c_REQ_U]    = pend_q[c_REQ_U]    | btn_u;
    req[c_REQ_L]    = pend_q[c_REQ_L]    | btn_l;
    req[c_REQ_R]    = pend_q[c_REQ_R]    | btn_r;
    req[c_REQ_D]    = pend_q[c_REQ_D]    | btn_d;
    req[c_REQ_TICK] = pend_q[c_REQ_TICK] | tick_1hz;

    // Isolate the lowest set bit: that is the highest-priority request.
    grant = req & (~req + 5'd1);

    if (grant[c_REQ_U]) add_val = ADD_U;
    if (grant[c_REQ_L]) add_val = ADD_L;
    if (grant[c_REQ_R]) add_val = ADD_R;
    if (grant[c_REQ_D]) add_val = ADD_D;
    sum = bcd_add(time_q, add_val);

    if (sw1 || sw0) begin
      // Preset owns the cycle; everything pending or arriving is dropped.
      time_nx = sw1 ? PRE1 : PRE0;
      pend_nx = '0;
    end else begin
      pend_nx = req & ~grant;
      if (grant[c_REQ_TICK]) begin
        if (time_q != 16'h0000) begin
          time_nx = bcd_dec(time_q);
        end
      end else if (grant != 5'd0) begin
        time_nx = sum[16] ? c_MAX_TIME : sum[15:0];
      end
    end

    // Valid BCD orders the same as binary, so plain compares are safe.
    if (time_nx == 16'h0000) begin
      state_nx = ST_EXPIRED;
    end else if (time_nx <= LOW_TH) begin
      state_nx = ST_LOW;
    end else begin
      state_nx = ST_RUN;
    end

    if (state_nx != state) begin
      phase_nx = 2'd0;
    end else if (tick_2hz) begin
      phase_nx = phase_q + 2'd1;
    end

    case (state_nx)
      ST_RUN:     blank_nx = 1'b0;
      ST_LOW:     blank_nx = phase_nx[0];
      ST_EXPIRED: blank_nx = phase_nx[1];
      default:    blank_nx = 1'b0;
    endcase
  end

  assign time_bcd = time_q;
  assign blank    = blank_q;
  assign expired  = (state == ST_EXPIRED);
  assign busy     = |pend_q;

endmodule
`default_nettype wire

// File: tb/tb_parking_meter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parking_meter_ctrl
//  Description : Self-checking bench for parking_meter_ctrl. Stimulus drives
//                inputs on the falling edge and pushes the reference model's
//                expected post-edge outputs into a scoreboard queue; a monitor
//                pops and compares just after each rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_meter_ctrl;

  localparam logic [15:0] P_ADD_U  = 16'h0010;
  localparam logic [15:0] P_ADD_L  = 16'h0180;
  localparam logic [15:0] P_ADD_R  = 16'h0200;
  localparam logic [15:0] P_ADD_D  = 16'h0550;
  localparam logic [15:0] P_PRE0   = 16'h0010;
  localparam logic [15:0] P_PRE1   = 16'h0205;
  localparam logic [15:0] P_LOW_TH = 16'h0200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_1hz = 1'b0, tick_2hz = 1'b0;
  logic        btn_u = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_d = 1'b0;
  logic        sw0 = 1'b0, sw1 = 1'b0;
  logic [15:0] time_bcd;
  logic        blank, expired, busy;

  always #5 clk = ~clk;

  parking_meter_ctrl #(
    .ADD_U(P_ADD_U), .ADD_L(P_ADD_L), .ADD_R(P_ADD_R), .ADD_D(P_ADD_D),
    .PRE0(P_PRE0), .PRE1(P_PRE1), .LOW_TH(P_LOW_TH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .btn_u(btn_u), .btn_l(btn_l), .btn_r(btn_r), .btn_d(btn_d),
    .sw0(sw0), .sw1(sw1), .time_bcd(time_bcd), .blank(blank),
    .expired(expired), .busy(busy)
  );

  typedef struct packed {
    logic [15:0] t;
    logic        blank;
    logic        expired;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // ---------------- reference model (decimal integers) ----------------
  int m_time = 0;          // seconds as a decimal number 0..9999
  bit m_pend[5];           // 0=U 1=L 2=R 3=D 4=tick, index = priority
  int m_mode = 0;          // 0 expired, 1 low, 2 run
  int m_phase = 0;         // 0..3

  function automatic int bcd2int(input logic [15:0] b);
    return b[15:12] * 1000 + b[11:8] * 100 + b[7:4] * 10 + b[3:0];
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic model_edge(input bit rn, input bit s0, input bit s1,
                            input bit u, input bit l, input bit r, input bit d,
                            input bit t1, input bit t2);
    bit req[5];
    int adds[4];
    int new_mode;
    bit served;
    exp_t e;
    adds[0] = bcd2int(P_ADD_U); adds[1] = bcd2int(P_ADD_L);
    adds[2] = bcd2int(P_ADD_R); adds[3] = bcd2int(P_ADD_D);
    if (!rn) begin
      m_time = 0; m_mode = 0; m_phase = 0;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
    end else begin
      if (s1 || s0) begin
        m_time = s1 ? bcd2int(P_PRE1) : bcd2int(P_PRE0);
        foreach (m_pend[i]) m_pend[i] = 1'b0;
      end else begin
        req[0] = m_pend[0] | u; req[1] = m_pend[1] | l;
        req[2] = m_pend[2] | r; req[3] = m_pend[3] | d;
        req[4] = m_pend[4] | t1;
        served = 1'b0;
        for (int i = 0; i < 5; i++) begin
          m_pend[i] = req[i];
          if (req[i] && !served) begin
            served = 1'b1;
            m_pend[i] = 1'b0;
            if (i < 4) m_time = (m_time + adds[i] > 9999) ? 9999 : m_time + adds[i];
            else if (m_time > 0) m_time = m_time - 1;
          end
        end
      end
      new_mode = (m_time == 0) ? 0 : (m_time <= bcd2int(P_LOW_TH)) ? 1 : 2;
      if (new_mode != m_mode) m_phase = 0;
      else if (t2) m_phase = (m_phase + 1) % 4;
      m_mode = new_mode;
    end
    e.t       = int2bcd(m_time);
    e.expired = (m_mode == 0);
    e.blank   = (m_mode == 2) ? 1'b0 : (m_mode == 1) ? m_phase[0] : m_phase[1];
    e.busy    = 1'b0;
    foreach (m_pend[i]) if (m_pend[i]) e.busy = 1'b1;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs on the falling edge and record expectations.
  task automatic apply(input bit rn, input bit s0, input bit s1,
                       input bit u, input bit l, input bit r, input bit d,
                       input bit t1, input bit t2);
    @(negedge clk);
    rst_n = rn; sw0 = s0; sw1 = s1;
    btn_u = u; btn_l = l; btn_r = r; btn_d = d;
    tick_1hz = t1; tick_2hz = t2;
    model_edge(rn, s0, s1, u, l, r, d, t1, t2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 1, 1, 1, 1, 1, 1);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (time_bcd !== e.t) begin
        miscompares++;
        $display("FAIL time_bcd @%0t: got %h expected %h", $time, time_bcd, e.t);
      end
      if (blank !== e.blank) begin
        miscompares++;
        $display("FAIL blank @%0t: got %b expected %b (time %h)", $time, blank, e.blank, e.t);
      end
      if (expired !== e.expired) begin
        miscompares++;
        $display("FAIL expired @%0t: got %b expected %b", $time, expired, e.expired);
      end
      if (busy !== e.busy) begin
        miscompares++;
        $display("FAIL busy @%0t: got %b expected %b", $time, busy, e.busy);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit hs0, hs1;
    do_reset();
    idle(2);
    // single up press from 0000
    apply(1, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(2);

    // simultaneous U, R and tick: served over three cycles
    do_reset();
    apply(1, 0, 0, 1, 0, 1, 0, 1, 0);
    idle(4);

    // climb to 9990 then saturate
    do_reset();
    for (int i = 0; i < 18; i++) apply(1, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++)  apply(1, 0, 0, 1, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 1, 0, 0);
    apply(1, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(1);

    // borrow across digits and countdown to zero
    do_reset();
    for (int i = 0; i < 10; i++) apply(1, 0, 0, 1, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 1, 0);
    do_reset();
    apply(1, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) apply(1, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      apply(1, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(1);
    end
    apply(1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);

    // preset discards a concurrent button; repeat strobes absorbed
    apply(1, 0, 1, 0, 1, 0, 0, 0, 0);
    apply(1, 0, 1, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 1, 1, 1, 1, 1, 1, 1, 0);
    apply(1, 1, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 1, 1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(3);

    // LOW flash sequence, then reset mid-sequence
    do_reset();
    for (int i = 0; i < 15; i++) apply(1, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      apply(1, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(1);
    end
    apply(1, 0, 0, 0, 0, 0, 0, 0, 1);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 1);
    do_reset();
    idle(2);

    // randomized traffic
    hs0 = 0; hs1 = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hs0) hs0 = ($urandom_range(0, 2) != 0); else hs0 = ($urandom_range(0, 99) == 0);
      if (hs1) hs1 = ($urandom_range(0, 2) != 0); else hs1 = ($urandom_range(0, 149) == 0);
      apply($urandom_range(0, 299) != 0, hs0, hs1,
            $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    end
    idle(2);

    // drain with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
